// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store unit for a 5-stage RV32I pipeline. It takes the
// EX/MEM control (store_mem, load_mem, size, sign), the effective address and
// the store data. It runs one request/grant/response transaction on the
// data-memory port and returns an aligned, sign- or zero-extended load result.
// The pipeline is held with stall until the access completes.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   store_mem       EX/MEM instruction is a store (wins if load_mem is also set)
//   load_mem        EX/MEM instruction is a load
//   size            access size in bytes: 1, 2 or 4 (anything else is illegal)
//   sign            sign-extend the load result (size 1 or 2 only)
//   addr            effective byte address
//   store_data      rs2 value; the low `size` bytes are significant
//   dmem_req/we     memory request valid / request is a write
//   dmem_addr       word-aligned address
//   dmem_be         byte-lane enables
//   dmem_wdata      lane-replicated write data
//   dmem_gnt        memory accepts the request this cycle
//   dmem_rvalid     read data valid (honoured only while waiting for it)
//   dmem_rdata      read word
//   stall           hold PC and the IF/ID, ID/EX and EX/MEM registers
//   load_data       registered, extended load result
//   misalign_err    registered; the last access was misaligned or illegal size
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            store_mem,
  input  logic            load_mem,
  input  logic [2:0]      size,
  input  logic            sign,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GNT   = 2'd1,
    WAIT_RDATA = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Attributes captured when an access starts, so the port stays stable while
  // the FSM waits for the memory.
  logic [1:0] off_q;
  logic [2:0] size_q;
  logic       sign_q;
  logic       store_q;

  // ---------------------------------------------------------------------------
  // Decode of the access presented in IDLE
  // ---------------------------------------------------------------------------
  logic pending;
  logic is_store;
  logic misaligned;

  assign pending  = load_mem | store_mem;
  assign is_store = store_mem;

  always_comb begin
    unique case (size)
      3'd1:    misaligned = 1'b0;
      3'd2:    misaligned = addr[0];
      3'd4:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane steering: fields come straight from the inputs in IDLE and from the
  // captured copies afterwards. addr and store_data are held by EX/MEM while
  // stall is high, so they do not need their own capture registers.
  // ---------------------------------------------------------------------------
  logic [1:0] eff_off;
  logic [2:0] eff_size;
  logic       eff_store;

  assign eff_off   = (state_q == IDLE) ? addr[1:0] : off_q;
  assign eff_size  = (state_q == IDLE) ? size      : size_q;
  assign eff_store = (state_q == IDLE) ? is_store  : store_q;

  logic [3:0]      be_lanes;
  logic [XLEN-1:0] wdata_lanes;

  // NOTE: every signal written in always_comb gets a value on every path
  // (default arm or up-front assignment); a missing path infers a latch.
  always_comb begin
    unique case (eff_size)
      3'd1:    be_lanes = 4'b0001 << eff_off;
      3'd2:    be_lanes = 4'b0011 << eff_off;
      3'd4:    be_lanes = 4'b1111;
      default: be_lanes = 4'b0000;
    endcase
  end

  always_comb begin
    unique case (eff_size)
      3'd1:    wdata_lanes = {4{store_data[7:0]}};
      3'd2:    wdata_lanes = {2{store_data[15:0]}};
      default: wdata_lanes = store_data;
    endcase
  end

  // Load extraction: shift the addressed byte down to lane 0, then extend.
  logic [XLEN-1:0] rdata_shift;
  logic [XLEN-1:0] rdata_ext;

  assign rdata_shift = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (size_q)
      3'd1:    rdata_ext = {{24{sign_q & rdata_shift[7]}},  rdata_shift[7:0]};
      3'd2:    rdata_ext = {{16{sign_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: rdata_ext = rdata_shift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values regardless of the order in which blocks evaluate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          if (misaligned)    state_d = DONE;
          else if (dmem_gnt) state_d = is_store ? DONE : WAIT_RDATA;
          else               state_d = WAIT_GNT;
        end
      end
      WAIT_GNT:   if (dmem_gnt)    state_d = store_q ? DONE : WAIT_RDATA;
      WAIT_RDATA: if (dmem_rvalid) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. req and stall are gated by rst so they drop the moment reset
  // is asserted, not at the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req = pending & ~misaligned;
        stall    = pending;
      end
      WAIT_GNT: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
      end
      WAIT_RDATA: stall = 1'b1;
      default: ;
    endcase
    if (rst) begin
      dmem_req = 1'b0;
      stall    = 1'b0;
    end
  end

  assign dmem_we    = eff_store;
  assign dmem_addr  = {addr[XLEN-1:2], 2'b00};
  assign dmem_be    = be_lanes;
  assign dmem_wdata = wdata_lanes;

  // ---------------------------------------------------------------------------
  // Capture and result registers
  // ---------------------------------------------------------------------------
  logic start;
  assign start = (state_q == IDLE) & pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q        <= 2'b00;
      size_q       <= 3'd0;
      sign_q       <= 1'b0;
      store_q      <= 1'b0;
      load_data    <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (start) begin
        off_q        <= addr[1:0];
        size_q       <= size;
        sign_q       <= sign;
        store_q      <= is_store;
        misalign_err <= misaligned;
        if (misaligned) load_data <= '0;
      end
      if ((state_q == WAIT_RDATA) && dmem_rvalid) load_data <= rdata_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// Directed bench for mem_access_unit. Inputs change 1 time unit after the
// rising edge and outputs are sampled 1 time unit after that, well away from
// the edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_mem, load_mem, sign;
  logic [2:0]  size;
  logic [31:0] addr, store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .store_mem    (store_mem),
    .load_mem     (load_mem),
    .size         (size),
    .sign         (sign),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .load_data    (load_data),
    .misalign_err (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    store_mem   = 1'b0;
    load_mem    = 1'b0;
    size        = 3'd4;
    sign        = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // Store with grant in the first cycle: one stall cycle, then DONE.
  task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    store_mem = 1'b1; addr = a; size = sz; store_data = d; dmem_gnt = 1'b1;
    #1;
    check({tag, " req"},   32'(dmem_req), 32'd1);
    check({tag, " we"},    32'(dmem_we),  32'd1);
    check({tag, " be"},    32'(dmem_be),  32'(exp_be));
    check({tag, " wdata"}, dmem_wdata,    exp_wdata);
    check({tag, " waddr"}, dmem_addr,     {a[31:2], 2'b00});
    check({tag, " stall"}, 32'(stall),    32'd1);
    step();
    dmem_gnt = 1'b0;
    #1;
    check({tag, " done stall"}, 32'(stall),        32'd0);
    check({tag, " done req"},   32'(dmem_req),     32'd0);
    check({tag, " done err"},   32'(misalign_err), 32'd0);
    store_mem = 1'b0;
    step();
  endtask

  // Load with gnt_wait cycles before the grant and rv_wait cycles before
  // rvalid. Counts cycles in which stall is observed high.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic sg, input logic [31:0] rd, input int gnt_wait,
                         input int rv_wait, input logic [3:0] exp_be,
                         input logic [31:0] exp_data, input int exp_stall);
    int stall_cycles = 0;
    load_mem = 1'b1; addr = a; size = sz; sign = sg;
    for (int i = 0; i < gnt_wait; i++) begin
      dmem_gnt = 1'b0;
      #1;
      check({tag, " req wait"}, 32'(dmem_req), 32'd1);
      check({tag, " be wait"},  32'(dmem_be),  32'(exp_be));
      if (stall) stall_cycles++;
      step();
    end
    dmem_gnt = 1'b1;
    #1;
    check({tag, " req"}, 32'(dmem_req), 32'd1);
    check({tag, " we"},  32'(dmem_we),  32'd0);
    check({tag, " be"},  32'(dmem_be),  32'(exp_be));
    if (stall) stall_cycles++;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < rv_wait; i++) begin
      #1;
      if (stall) stall_cycles++;
      step();
    end
    dmem_rvalid = 1'b1; dmem_rdata = rd;
    #1;
    check({tag, " req off"}, 32'(dmem_req), 32'd0);
    if (stall) stall_cycles++;
    step();
    dmem_rvalid = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check({tag, " done stall"}, 32'(stall),     32'd0);
    check({tag, " data"},       load_data,      exp_data);
    check({tag, " stall cyc"},  32'(stall_cycles), 32'(exp_stall));
    load_mem = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    addr = 32'h0; store_data = 32'h0; dmem_rdata = 32'h0;
    store_mem = 1'b1;   // req must stay low while in reset
    #12;
    check("rst req",  32'(dmem_req),     32'd0);
    check("rst stall", 32'(stall),       32'd0);
    check("rst data", load_data,         32'd0);
    check("rst err",  32'(misalign_err), 32'd0);
    store_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Aligned word store, granted immediately.
    do_store("sw", 32'h0000_0100, 3'd4, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);

    // Signed byte load at lane 3, two grant wait cycles, rvalid next cycle.
    do_load("lb", 32'h0000_0203, 3'd1, 1'b1, 32'h8011_2233, 2, 0, 4'h8, 32'hFFFF_FF80, 4);

    // Unsigned halfword from the upper lanes.
    do_load("lhu", 32'h0000_0202, 3'd2, 1'b0, 32'h9ABC_1234, 0, 0, 4'hC, 32'h0000_9ABC, 2);

    // Signed halfword, lower lanes, one rvalid wait cycle.
    do_load("lh", 32'h0000_0300, 3'd2, 1'b1, 32'h0000_8001, 0, 1, 4'h3, 32'hFFFF_8001, 3);

    // Misaligned halfword store: no request, error set, load_data cleared.
    store_mem = 1'b1; addr = 32'h0000_0001; size = 3'd2; store_data = 32'h1111_2222;
    dmem_gnt = 1'b1;
    #1;
    check("mis req",   32'(dmem_req), 32'd0);
    check("mis stall", 32'(stall),    32'd1);
    step();
    dmem_gnt = 1'b0;
    #1;
    check("mis err",        32'(misalign_err), 32'd1);
    check("mis data",       load_data,         32'd0);
    check("mis done stall", 32'(stall),        32'd0);
    store_mem = 1'b0;
    step();
    check("mis err held", 32'(misalign_err), 32'd1);

    // Aligned word load clears the error once it starts.
    load_mem = 1'b1; addr = 32'h0000_0040; size = 3'd4; sign = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    check("lw err clr", 32'(misalign_err), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    #1;
    check("lw data", load_data, 32'h1234_5678);
    load_mem = 1'b0;
    step();

    // Illegal size is treated as misaligned.
    load_mem = 1'b1; addr = 32'h0000_0000; size = 3'd3;
    #1;
    check("sz3 req", 32'(dmem_req), 32'd0);
    step();
    #1;
    check("sz3 err",  32'(misalign_err), 32'd1);
    check("sz3 data", load_data,         32'd0);
    load_mem = 1'b0;
    step();

    // Byte store at lane 3.
    do_store("sb", 32'h0000_0003, 3'd1, 32'h0000_00A5, 4'h8, 32'hA5A5_A5A5);

    // Build a non-zero load_data, then reset in WAIT_RDATA.
    do_load("lw2", 32'h0000_0104, 3'd4, 1'b0, 32'hCAFE_F00D, 0, 0, 4'hF, 32'hCAFE_F00D, 2);
    load_mem = 1'b1; addr = 32'h0000_0108; size = 3'd4; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    check("pre-rst stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst mid stall", 32'(stall),   32'd0);
    check("rst mid data",  load_data,    32'd0);
    check("rst mid req",   32'(dmem_req), 32'd0);
    load_mem = 1'b0;
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    dmem_rvalid = 1'b0;
    #1;
    check("late rv data",  load_data,    32'd0);
    check("late rv stall", 32'(stall),   32'd0);
    check("late rv req",   32'(dmem_req), 32'd0);

    // A store right after confirms the FSM is back in IDLE.
    do_store("sh", 32'h0000_0012, 3'd2, 32'h0000_BEEF, 4'hC, 32'hBEEF_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
